// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the streaming CRC engine:
//   - CRC-32/MPEG-2 constants (polynomial, init, output XOR, good residue)
//   - crc_state_e : packet-level FSM states
//   - rev_bits    : reverses the low 'width' bits of a 32-bit value
// ---------------------------------------------------------------------------
package crc_pkg;

  localparam logic [31:0] CRC_MPEG2_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_MPEG2_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_MPEG2_XOR     = 32'h00000000;
  localparam logic [31:0] CRC_MPEG2_RESIDUE = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } crc_state_e;

  // Bits at or above 'width' come back as zero, so the caller can take the
  // low 'width' bits as the reversed value of a narrower CRC.
  function automatic logic [31:0] rev_bits(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r[i] = value[width-1-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_step.sv
// ---------------------------------------------------------------------------
// crc_step
// Purely combinational next-CRC for one beat.
// The register shifts left, MSB-first. The first byte on the wire is
// data[DATA_W-1 -: 8].
// Ports:
//   crc_in   [CRC_W-1:0]  current CRC register
//   data     [DATA_W-1:0] beat data
//   nbytes   [BW-1:0]     bytes to feed; 0 or more than DATA_W/8 means a full beat
//   crc_next [CRC_W-1:0]  register after feeding the selected bytes
// ---------------------------------------------------------------------------
module crc_step
  import crc_pkg::*;
#(
  parameter int          DATA_W = 48,
  parameter int          CRC_W  = 32,
  parameter logic [31:0] POLY   = CRC_MPEG2_POLY,
  parameter bit          REFIN  = 1'b0,
  localparam int         NB     = DATA_W / 8,
  localparam int         BW     = $clog2(NB + 1)
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  input  logic [BW-1:0]     nbytes,
  output logic [CRC_W-1:0]  crc_next
);

  logic [CRC_W-1:0] c;
  logic [7:0]       b;
  logic [31:0]      brev;
  logic             fb;
  int               eff;

  // Bit-serial division unrolled over every byte lane. Lanes at or beyond the
  // effective byte count are skipped entirely. They are not fed as zeros, so
  // a partial last beat gives the same CRC as a shorter packet.
  always_comb begin
    c    = crc_in;
    b    = '0;
    brev = '0;
    fb   = 1'b0;
    eff  = ((nbytes == '0) || (int'(nbytes) > NB)) ? NB : int'(nbytes);
    for (int k = 0; k < NB; k++) begin
      if (k < eff) begin
        b = data[DATA_W-1-8*k -: 8];
        if (REFIN) begin
          brev = rev_bits({24'h000000, b}, 8);
          b    = brev[7:0];
        end
        for (int i = 7; i >= 0; i--) begin
          fb = c[CRC_W-1] ^ b[i];
          c  = {c[CRC_W-2:0], 1'b0};
          if (fb) begin
            c = c ^ POLY[CRC_W-1:0];
          end
        end
      end
    end
    crc_next = c;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// ---------------------------------------------------------------------------
// crc_stream_engine
// Packet-level streaming CRC. It takes DATA_W-bit beats with SOP/EOP framing
// and a partial last beat, then returns the final CRC one cycle after EOP.
// In check mode it also flags a good residue.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   in_valid       beat present
//   in_ready       beat accepted this cycle when in_valid is also high
//   in_sop         first beat of a packet
//   in_eop         last beat of a packet
//   in_bytes       valid bytes on an EOP beat (0 or more than DATA_W/8 = full)
//   in_check       mode, sampled on SOP (1 = check, 0 = generate)
//   data           beat data, first wire byte in the top byte
//   out_valid      result valid; held until out_ready
//   out_ready      downstream takes the result
//   crc_out        final CRC after REFOUT and XOR_OUT
//   crc_ok         check mode: raw register equals RESIDUE
//   proto_err      one-cycle pulse on a framing error
// ---------------------------------------------------------------------------
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int          DATA_W  = 48,
  parameter int          CRC_W   = 32,
  parameter logic [31:0] POLY    = CRC_MPEG2_POLY,
  parameter logic [31:0] INIT    = CRC_MPEG2_INIT,
  parameter logic [31:0] XOR_OUT = CRC_MPEG2_XOR,
  parameter bit          REFIN   = 1'b0,
  parameter bit          REFOUT  = 1'b0,
  parameter logic [31:0] RESIDUE = CRC_MPEG2_RESIDUE,
  localparam int         NB      = DATA_W / 8,
  localparam int         BW      = $clog2(NB + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [BW-1:0]     in_bytes,
  input  logic              in_check,
  input  logic [DATA_W-1:0] data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_ok,
  output logic              proto_err
);

  crc_state_e       state;
  crc_state_e       beat_state;
  logic [CRC_W-1:0] crc_q;
  logic             chk_q;
  logic             accept;
  logic             pkt_check;
  logic [CRC_W-1:0] step_in;
  logic [BW-1:0]    step_bytes;
  logic [CRC_W-1:0] step_out;
  logic [31:0]      crc_ext;
  logic [31:0]      crc_rev;
  logic [CRC_W-1:0] crc_final;

  // A waiting result blocks new beats only until downstream takes it. Then a
  // new packet can start in the same cycle.
  assign in_ready = (state != DONE) || out_ready;
  assign accept   = in_valid && in_ready;

  // A beat accepted in DONE is taken together with the result handshake, so
  // it is handled as if the engine were already idle.
  assign beat_state = (state == DONE) ? IDLE : state;

  // An SOP beat always restarts from INIT. This also covers an SOP that
  // aborts a packet in progress.
  assign step_in    = in_sop ? INIT[CRC_W-1:0] : crc_q;
  assign step_bytes = in_eop ? in_bytes : BW'(NB);
  assign pkt_check  = in_sop ? in_check : chk_q;

  crc_step #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .REFIN  (REFIN)
  ) u_step (
    .crc_in   (step_in),
    .data     (data),
    .nbytes   (step_bytes),
    .crc_next (step_out)
  );

  // Output transform. The raw register value is kept separately, because the
  // residue check compares the register before reflection and XOR.
  always_comb begin
    crc_ext               = '0;
    crc_ext[CRC_W-1:0]    = step_out;
    crc_rev               = rev_bits(crc_ext, CRC_W);
    crc_final             = (REFOUT ? crc_rev[CRC_W-1:0] : step_out) ^ XOR_OUT[CRC_W-1:0];
  end

  // Packet FSM with registered outputs. A result is held in DONE until
  // out_ready. A beat accepted in the same cycle then runs through the idle
  // rules. proto_err is high for only one cycle, and the rules below set it
  // when they need to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc_q     <= INIT[CRC_W-1:0];
      chk_q     <= 1'b0;
      out_valid <= 1'b0;
      crc_out   <= '0;
      crc_ok    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
        state     <= IDLE;
      end
      if (accept) begin
        if (in_sop) begin
          chk_q <= in_check;
          if (beat_state == BUSY) begin
            proto_err <= 1'b1;
          end
        end
        if (!in_sop && beat_state == IDLE) begin
          proto_err <= 1'b1;
        end else if (in_eop) begin
          crc_q     <= step_out;
          crc_out   <= crc_final;
          crc_ok    <= pkt_check && (step_out == RESIDUE[CRC_W-1:0]);
          out_valid <= 1'b1;
          state     <= DONE;
        end else begin
          crc_q <= step_out;
          state <= BUSY;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_crc_stream_engine
// Three engines driven by the same stimulus:
//   dut0 : CRC-32/MPEG-2 defaults
//   dut1 : XOR_OUT = FFFFFFFF (CRC-32/BZIP2)
//   dut2 : REFIN = REFOUT = 1, XOR_OUT = FFFFFFFF (CRC-32)
// Expected values come from a table-driven, byte-wise reference CRC.
// ---------------------------------------------------------------------------
module tb_crc_stream_engine;

  localparam int          DATA_W = 48;
  localparam int          NB     = DATA_W / 8;
  localparam int          BW     = $clog2(NB + 1);
  localparam logic [31:0] POLY   = 32'h04C11DB7;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid;
  logic              in_sop;
  logic              in_eop;
  logic [BW-1:0]     in_bytes;
  logic              in_check;
  logic [DATA_W-1:0] data;
  logic              out_ready;

  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [31:0] crc_out_w   [3];
  logic        crc_ok_w    [3];
  logic        proto_err_w [3];

  int passed = 0;
  int total  = 0;

  logic [31:0] tbl [256];

  always #5 clk = ~clk;

  crc_stream_engine dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_sop(in_sop), .in_eop(in_eop), .in_bytes(in_bytes), .in_check(in_check),
    .data(data), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .crc_out(crc_out_w[0]), .crc_ok(crc_ok_w[0]), .proto_err(proto_err_w[0])
  );

  crc_stream_engine #(.XOR_OUT(32'hFFFFFFFF)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_sop(in_sop), .in_eop(in_eop), .in_bytes(in_bytes), .in_check(in_check),
    .data(data), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .crc_out(crc_out_w[1]), .crc_ok(crc_ok_w[1]), .proto_err(proto_err_w[1])
  );

  crc_stream_engine #(.XOR_OUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_sop(in_sop), .in_eop(in_eop), .in_bytes(in_bytes), .in_check(in_check),
    .data(data), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .crc_out(crc_out_w[2]), .crc_ok(crc_ok_w[2]), .proto_err(proto_err_w[2])
  );

  // Stops a stuck run with a visible failure instead of hanging.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Byte-at-a-time table CRC starting from FFFFFFFF. Returns the register
  // before any output reflection or XOR.
  function automatic logic [31:0] model_raw(input logic [7:0] q[$], input bit refl);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      b = refl ? rev8(q[i]) : q[i];
      c = (c << 8) ^ tbl[c[31:24] ^ b];
    end
    return c;
  endfunction

  task automatic drive_beat(input bit sop, input bit eop, input logic [BW-1:0] nb,
                            input bit chk, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    in_bytes = nb;
    in_check = chk;
    data     = d;
    tick();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // Compares all three engines against the model while their result is valid.
  task automatic check_result(input logic [7:0] q[$], input bit chk, input string tag);
    logic [31:0] raw, rawr;
    logic [31:0] exp_crc [3];
    logic        exp_ok  [3];
    raw        = model_raw(q, 1'b0);
    rawr       = model_raw(q, 1'b1);
    exp_crc[0] = raw;
    exp_crc[1] = raw ^ 32'hFFFFFFFF;
    exp_crc[2] = rev32(rawr) ^ 32'hFFFFFFFF;
    exp_ok[0]  = chk && (raw == 32'h0);
    exp_ok[1]  = chk && (raw == 32'h0);
    exp_ok[2]  = chk && (rawr == 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/valid%0d", tag, i), {31'h0, out_valid_w[i]}, 32'h1);
      check($sformatf("%s/crc%0d", tag, i), crc_out_w[i], exp_crc[i]);
      check($sformatf("%s/ok%0d", tag, i), {31'h0, crc_ok_w[i]}, {31'h0, exp_ok[i]});
    end
  endtask

  // Splits the bytes into beats. The unused bytes of the last beat are
  // random, and a full last beat is sometimes flagged with 0 or 7. The
  // in_check and in_bytes values on non-SOP and non-EOP beats are random.
  task automatic send_pkt(input logic [7:0] q[$], input bit chk, input bit exp_perr,
                          input string tag);
    int                n, nbeats, rem;
    logic [DATA_W-1:0] d;
    logic [BW-1:0]     nb;
    bit                last;
    n      = q.size();
    nbeats = (n + NB - 1) / NB;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < NB; k++) begin
        d[DATA_W-1-8*k -: 8] = (b*NB + k < n) ? q[b*NB + k] : 8'($urandom);
      end
      last = (b == nbeats - 1);
      rem  = n - NB*b;
      if (last && rem < NB) nb = BW'(rem);
      else if (last) begin
        case ($urandom_range(2))
          0:       nb = BW'(0);
          1:       nb = BW'(NB);
          default: nb = BW'(7);
        endcase
      end else nb = BW'($urandom_range(7));
      drive_beat(b == 0, last, nb, (b == 0) ? chk : 1'($urandom), d);
      if (b == 0) check({tag, "/perr"}, {31'h0, proto_err_w[0]}, {31'h0, exp_perr});
    end
    idle_inputs();
    check_result(q, chk, tag);
  endtask

  initial begin
    logic [7:0]  ascii[$];
    logic [7:0]  q[$];
    logic [7:0]  qb[$];
    logic [31:0] r;
    logic [DATA_W-1:0] d;
    string       s;
    int          n;
    bit          chk;

    for (int i = 0; i < 256; i++) begin
      r = 32'(i) << 24;
      for (int j = 0; j < 8; j++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
      tbl[i] = r;
    end
    s = "123456789";
    for (int i = 0; i < s.len(); i++) ascii.push_back(s[i]);

    idle_inputs();
    in_bytes  = '0;
    in_check  = 1'b0;
    data      = '0;
    out_ready = 1'b1;

    $display("[TB] reset");
    #2 rst_n = 1'b0;
    #1;
    check("rst/out_valid", {31'h0, out_valid_w[0]}, 32'h0);
    check("rst/crc_out", crc_out_w[0], 32'h0);
    check("rst/crc_ok", {31'h0, crc_ok_w[0]}, 32'h0);
    check("rst/proto_err", {31'h0, proto_err_w[0]}, 32'h0);
    check("rst/in_ready", {31'h0, in_ready_w[0]}, 32'h1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] generate mode, 123456789");
    send_pkt(ascii, 1'b0, 1'b0, "ascii");
    check("ascii/mpeg2", crc_out_w[0], 32'h0376E6E7);
    check("ascii/bzip2", crc_out_w[1], 32'hFC891918);
    check("ascii/crc32", crc_out_w[2], 32'hCBF43926);

    $display("[TB] check mode, good and corrupted");
    q = ascii;
    q.push_back(8'h03); q.push_back(8'h76); q.push_back(8'hE6); q.push_back(8'hE7);
    send_pkt(q, 1'b1, 1'b0, "chk_good");
    check("chk_good/const", {31'h0, crc_ok_w[0]}, 32'h1);
    q[4] = q[4] ^ 8'h10;
    send_pkt(q, 1'b1, 1'b0, "chk_bad");
    check("chk_bad/const", {31'h0, crc_ok_w[0]}, 32'h0);

    $display("[TB] random packets");
    for (int p = 0; p < 10; p++) begin
      n = $urandom_range(1, 20);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      chk = 1'($urandom);
      if (chk && $urandom_range(1) == 1) begin
        r = model_raw(q, 1'b0);
        for (int i = 3; i >= 0; i--) q.push_back(r[8*i +: 8]);
      end
      send_pkt(q, chk, 1'b0, $sformatf("rnd%0d", p));
    end

    $display("[TB] backpressure");
    tick();
    out_ready = 1'b0;
    send_pkt(ascii, 1'b0, 1'b0, "bp");
    d = DATA_W'({$urandom, $urandom});
    qb = {};
    for (int k = 0; k < 4; k++) qb.push_back(d[DATA_W-1-8*k -: 8]);
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1;
    in_bytes = BW'(4); in_check = 1'b0; data = d;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp/hold_valid%0d", c), {31'h0, out_valid_w[0]}, 32'h1);
      check($sformatf("bp/hold_crc%0d", c), crc_out_w[0], 32'h0376E6E7);
      check($sformatf("bp/hold_ready%0d", c), {31'h0, in_ready_w[0]}, 32'h0);
    end
    out_ready = 1'b1;
    tick();
    idle_inputs();
    check_result(qb, 1'b0, "bp_next");

    $display("[TB] beat without SOP");
    tick();
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'($urandom);
    tick();
    idle_inputs();
    check("nosop/perr", {31'h0, proto_err_w[0]}, 32'h1);
    check("nosop/valid", {31'h0, out_valid_w[0]}, 32'h0);
    tick();
    check("nosop/perr_drop", {31'h0, proto_err_w[0]}, 32'h0);
    check("nosop/valid2", {31'h0, out_valid_w[0]}, 32'h0);

    $display("[TB] SOP during BUSY");
    drive_beat(1'b1, 1'b0, BW'(0), 1'b1, DATA_W'({$urandom, $urandom}));
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(8'($urandom));
    send_pkt(q, 1'b0, 1'b1, "abort");

    $display("[TB] reset mid-packet");
    drive_beat(1'b1, 1'b0, BW'(0), 1'b0, {ascii[0], ascii[1], ascii[2], ascii[3], ascii[4], ascii[5]});
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("midrst/out_valid", {31'h0, out_valid_w[0]}, 32'h0);
    check("midrst/crc_out", crc_out_w[0], 32'h0);
    check("midrst/crc_ok", {31'h0, crc_ok_w[0]}, 32'h0);
    check("midrst/proto_err", {31'h0, proto_err_w[0]}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    send_pkt(ascii, 1'b0, 1'b0, "post_rst");
    check("post_rst/mpeg2", crc_out_w[0], 32'h0376E6E7);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
